// File: rtl/or1k_wb32_sram_slave.sv
// Wishbone B3 32-bit slave in front of a single-port on-chip SRAM.
// Handles classic cycles and registered-feedback bursts; out-of-window accesses get ERR.
module or1k_wb32_sram_slave #(
  parameter int          MEM_AW    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter bit          BURST_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic        wbs_we_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic [2:0]  wbs_cti_i,
  input  logic [1:0]  wbs_bte_i,
  output logic [31:0] wbs_dat_o,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic        wbs_rty_o
);

  localparam int DEPTH = 1 << MEM_AW;

  typedef enum logic [1:0] {IDLE, SINGLE, BURST, ERR} state_t;

  state_t            state, state_nxt;
  logic              ack_r, err_r;
  logic [MEM_AW-1:0] exp_adr, exp_nxt;
  logic [MEM_AW-1:0] word_adr, rd_adr;
  logic [31:0]       mem [DEPTH];
  logic [31:0]       rd_data, dat_r;
  logic              req, in_range, adr_match, burst_last, rd_en, wr_en;
  logic              unused_adr_lsb;

  function automatic logic [MEM_AW-1:0] next_adr(input logic [MEM_AW-1:0] a,
                                                 input logic [1:0] bte);
    logic [MEM_AW-1:0] n;
    n = a;
    case (bte)
      2'b00:   n      = a + MEM_AW'(1);
      2'b01:   n[1:0] = a[1:0] + 2'd1;
      2'b10:   n[2:0] = a[2:0] + 3'd1;
      default: n[3:0] = a[3:0] + 4'd1;
    endcase
    return n;
  endfunction

  assign unused_adr_lsb = ^wbs_adr_i[1:0];
  assign req        = wbs_cyc_i & wbs_stb_i;
  assign in_range   = (wbs_adr_i[31:MEM_AW+2] == BASE_ADDR[31:MEM_AW+2]);
  assign word_adr   = wbs_adr_i[MEM_AW+1:2];
  assign adr_match  = (word_adr == exp_adr);
  assign burst_last = (wbs_cti_i == 3'b111) || (wbs_cti_i == 3'b000);

  assign wbs_ack_o = ack_r & req & ((state != BURST) | adr_match);
  assign wbs_err_o = err_r;
  assign wbs_rty_o = 1'b0;
  assign wbs_dat_o = dat_r;
  assign wr_en     = wbs_ack_o & wbs_we_i & ~rst;

  always_comb begin
    state_nxt = state;
    exp_nxt   = exp_adr;
    rd_en     = 1'b0;
    rd_adr    = word_adr;
    case (state)
      IDLE: begin
        if (req) begin
          if (!in_range) begin
            state_nxt = ERR;
          end else begin
            rd_en     = 1'b1;
            exp_nxt   = word_adr;
            state_nxt = (BURST_EN && wbs_cti_i == 3'b010) ? BURST : SINGLE;
          end
        end
      end
      SINGLE: state_nxt = IDLE;
      BURST: begin
        // Abort, address mismatch or final beat all drop back to IDLE.
        if (!req || !adr_match || burst_last) begin
          state_nxt = IDLE;
        end else begin
          exp_nxt = next_adr(exp_adr, wbs_bte_i);
          rd_en   = 1'b1;
          rd_adr  = exp_nxt;
        end
      end
      ERR: state_nxt = IDLE;
    endcase
  end

  // Pre-read forwards bytes being written this cycle so back-to-back RAW is coherent.
  always_comb begin
    rd_data = mem[rd_adr];
    for (int n = 0; n < 4; n++) begin
      if (wr_en && wbs_sel_i[n] && rd_adr == word_adr)
        rd_data[8*n +: 8] = wbs_dat_i[8*n +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int n = 0; n < 4; n++) begin
        if (wbs_sel_i[n]) mem[word_adr][8*n +: 8] <= wbs_dat_i[8*n +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      exp_adr <= '0;
      dat_r   <= '0;
    end else begin
      state   <= state_nxt;
      ack_r   <= (state_nxt == SINGLE) || (state_nxt == BURST);
      err_r   <= (state_nxt == ERR);
      exp_adr <= exp_nxt;
      if (rd_en) dat_r <= rd_data;
    end
  end

endmodule

// File: tb/tb_or1k_wb32_sram_slave.sv
// Directed bench for or1k_wb32_sram_slave: classic, burst, error, abort and reset cases.
module tb_or1k_wb32_sram_slave;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr, dat_i, dat_o;
  logic [3:0]  sel;
  logic        we, cyc, stb, ack, err, rty;
  logic [2:0]  cti;
  logic [1:0]  bte;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  or1k_wb32_sram_slave #(.MEM_AW(10), .BASE_ADDR(32'h0), .BURST_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .wbs_adr_i(adr), .wbs_dat_i(dat_i), .wbs_sel_i(sel), .wbs_we_i(we),
    .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_cti_i(cti), .wbs_bte_i(bte),
    .wbs_dat_o(dat_o), .wbs_ack_o(ack), .wbs_err_o(err), .wbs_rty_o(rty)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_bus();
    cyc = 0; stb = 0; we = 0; sel = 0; adr = 0; dat_i = 0; cti = 0; bte = 0;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic w, input logic [2:0] c, input logic [1:0] b);
    cyc = 1; stb = 1; adr = a; dat_i = d; sel = s; we = w; cti = c; bte = b;
  endtask

  // Classic access: no ack in the request cycle, ack or err one cycle later.
  task automatic access(input string tag, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic w, input logic exp_err,
                        input logic [31:0] exp_dat);
    drive(a, d, s, w, 3'b000, 2'b00);
    smp();
    chk1({tag, "_ack_n0"}, ack, 1'b0);
    tick();
    smp();
    chk1({tag, "_ack_n1"}, ack, ~exp_err);
    chk1({tag, "_err_n1"}, err, exp_err);
    if (!w && !exp_err) chk({tag, "_dat"}, dat_o, exp_dat);
    tick();
    idle_bus();
  endtask

  logic [31:0] wrap_adr [4];
  logic [31:0] wrap_dat [4];

  initial begin
    wrap_adr = '{32'h18, 32'h1C, 32'h10, 32'h14};
    wrap_dat = '{32'h6666_0006, 32'h7777_0007, 32'hDEAD_BEAA, 32'h5555_0005};
    rst = 1;
    idle_bus();
    tick();
    tick();
    rst = 0;
    smp();
    chk1("rst_ack", ack, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_rty", rty, 1'b0);
    chk("rst_dat", dat_o, 32'h0);
    tick();

    // Reset held with a write request pending must not touch memory.
    access("w0", 32'h0, 32'h1111_2222, 4'hF, 1'b1, 1'b0, 32'h0);
    rst = 1;
    drive(32'h0, 32'hBAD0_BAD0, 4'hF, 1'b1, 3'b000, 2'b00);
    smp();
    chk1("rstreq_ack0", ack, 1'b0);
    tick();
    smp();
    chk1("rstreq_ack1", ack, 1'b0);
    chk1("rstreq_err1", err, 1'b0);
    chk("rstreq_dat1", dat_o, 32'h0);
    tick();
    rst = 0;
    idle_bus();
    access("r0", 32'h0, 32'h0, 4'hF, 1'b0, 1'b0, 32'h1111_2222);

    access("wdead", 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 32'h0);
    access("rdead", 32'h10, 32'h0, 4'hF, 1'b0, 1'b0, 32'hDEAD_BEEF);
    access("wbyte", 32'h10, 32'h0000_00AA, 4'b0001, 1'b1, 1'b0, 32'h0);
    access("rbyte", 32'h10, 32'h0, 4'hF, 1'b0, 1'b0, 32'hDEAD_BEAA);
    access("w5", 32'h14, 32'h5555_0005, 4'hF, 1'b1, 1'b0, 32'h0);
    access("w6", 32'h18, 32'h6666_0006, 4'hF, 1'b1, 1'b0, 32'h0);
    access("w7", 32'h1C, 32'h7777_0007, 4'hF, 1'b1, 1'b0, 32'h0);

    drive(32'h18, 32'h0, 4'hF, 1'b0, 3'b010, 2'b01);
    smp();
    chk1("wrap4_ack_n0", ack, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      adr = wrap_adr[i];
      cti = (i == 3) ? 3'b111 : 3'b010;
      smp();
      chk1($sformatf("wrap4_ack_b%0d", i), ack, 1'b1);
      chk($sformatf("wrap4_dat_b%0d", i), dat_o, wrap_dat[i]);
      tick();
    end
    idle_bus();
    smp();
    chk1("wrap4_ack_end", ack, 1'b0);
    tick();

    drive(32'hFF0, 32'hA000_0000, 4'hF, 1'b1, 3'b010, 2'b00);
    smp();
    chk1("lin_ack_n0", ack, 1'b0);
    tick();
    for (int i = 0; i < 8; i++) begin
      adr   = 32'(((1020 + i) % 1024) * 4);
      dat_i = 32'hA000_0000 + 32'(i);
      cti   = (i == 7) ? 3'b111 : 3'b010;
      smp();
      chk1($sformatf("lin_ack_b%0d", i), ack, 1'b1);
      tick();
    end
    idle_bus();
    smp();
    chk1("lin_ack_end", ack, 1'b0);
    tick();
    access("lin_r1020", 32'hFF0, 32'h0, 4'hF, 1'b0, 1'b0, 32'hA000_0000);
    access("lin_r1023", 32'hFFC, 32'h0, 4'hF, 1'b0, 1'b0, 32'hA000_0003);
    access("lin_r0", 32'h000, 32'h0, 4'hF, 1'b0, 1'b0, 32'hA000_0004);
    access("lin_r3", 32'h00C, 32'h0, 4'hF, 1'b0, 1'b0, 32'hA000_0007);

    access("err_rd", 32'h1000, 32'h0, 4'hF, 1'b0, 1'b1, 32'h0);
    smp();
    chk1("err_pulse_end", err, 1'b0);
    tick();
    access("err_wr", 32'h1000, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b1, 32'h0);
    access("err_nowr", 32'h0, 32'h0, 4'hF, 1'b0, 1'b0, 32'hA000_0004);

    access("w8", 32'h20, 32'h8888_0008, 4'hF, 1'b1, 1'b0, 32'h0);
    access("w9", 32'h24, 32'h9999_0009, 4'hF, 1'b1, 1'b0, 32'h0);
    access("w16", 32'h40, 32'h1616_1616, 4'hF, 1'b1, 1'b0, 32'h0);

    // Master jumps away on the third beat.
    drive(32'h20, 32'h0, 4'hF, 1'b0, 3'b010, 2'b00);
    smp();
    chk1("jmp_ack_n0", ack, 1'b0);
    tick();
    smp();
    chk1("jmp_ack_b0", ack, 1'b1);
    chk("jmp_dat_b0", dat_o, 32'h8888_0008);
    tick();
    adr = 32'h24;
    smp();
    chk1("jmp_ack_b1", ack, 1'b1);
    chk("jmp_dat_b1", dat_o, 32'h9999_0009);
    tick();
    adr = 32'h40;
    cti = 3'b111;
    smp();
    chk1("jmp_ack_mismatch", ack, 1'b0);
    tick();
    smp();
    chk1("jmp_ack_idle", ack, 1'b0);
    tick();
    smp();
    chk1("jmp_ack_restart", ack, 1'b1);
    chk("jmp_dat_restart", dat_o, 32'h1616_1616);
    tick();
    idle_bus();

    // Reset lands on the second beat of a burst.
    drive(32'h20, 32'h0, 4'hF, 1'b0, 3'b010, 2'b00);
    smp();
    chk1("rstb_ack_n0", ack, 1'b0);
    tick();
    smp();
    chk1("rstb_ack_b0", ack, 1'b1);
    tick();
    adr = 32'h24;
    rst = 1;
    tick();
    smp();
    chk1("rstb_ack_after", ack, 1'b0);
    chk1("rstb_err_after", err, 1'b0);
    chk("rstb_dat_after", dat_o, 32'h0);
    rst = 0;
    idle_bus();
    tick();
    access("rstb_fresh", 32'h24, 32'h0, 4'hF, 1'b0, 1'b0, 32'h9999_0009);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
